// File: rtl/libv_pkg.sv
// Shared types and helpers for the round-robin arbitration stage.
// Helpers work on vectors sized for the largest supported requester
// count; callers zero-extend their narrower vectors into these types.
package libv_pkg;

    // Arbiter FSM: free arbitration, or locked to one source mid-packet.
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Largest requester count the helpers can handle.
    localparam int unsigned MAX_N  = 32;
    localparam int unsigned MAX_IW = 5;

    typedef logic [MAX_N-1:0]  req_vec_t;
    typedef logic [MAX_IW-1:0] req_idx_t;

    // One-hot vector marking the first set bit of req, searching upward
    // from index ptr and wrapping past n-1 back to 0. Zero if req is empty.
    function automatic req_vec_t rr_pick(input req_vec_t    req,
                                         input req_idx_t    ptr,
                                         input int unsigned n);
        req_vec_t    pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_N; k++) begin
            if (k < n) begin
                idx = 32'(ptr) + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (!found && req[idx[MAX_IW-1:0]]) begin
                    pick[idx[MAX_IW-1:0]] = 1'b1;
                    found                 = 1'b1;
                end
            end
        end
        return pick;
    endfunction

    // Binary index of a one-hot vector; zero when the vector is empty.
    function automatic req_idx_t onehot_to_idx(input req_vec_t oh);
        req_idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | req_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/libv_mux.sv
// One-hot AND-OR multiplexer: y is the OR of every dat lane whose sel bit
// is set. With a one-hot sel this is a plain select; with sel = 0 it is 0.
module libv_mux #(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic [N-1:0]        sel,
    input  logic [N-1:0][W-1:0] dat,
    output logic [W-1:0]        y
);

    // OR together every selected lane.
    always_comb begin
        // NOTE: y is given a default before the loop so every path assigns
        // it; without this an always_comb would infer a latch.
        y = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i]) begin
                y = y | dat[i];
            end
        end
    end

endmodule

// File: rtl/libv_rr_arb_stage.sv
// Registered N-to-1 round-robin arbitration stage with packet locking.
// A combinational round-robin pick selects one valid requester when the
// output register can load; the winning beat is captured through a
// one-hot mux. A packet that starts with last=0 locks the arbiter to its
// source until the last beat transfers. N must lie in 2..libv_pkg::MAX_N.
module libv_rr_arb_stage
    import libv_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        in_vld,
    input  logic [N-1:0][W-1:0] in_dat,
    input  logic [N-1:0]        in_lst,
    output logic [N-1:0]        in_rdy,
    output logic                out_vld,
    output logic [W-1:0]        out_dat,
    output logic                out_lst,
    output logic [N-1:0]        out_gnt,
    input  logic                out_rdy
);

    localparam int IDX_W = $clog2(N);

    arb_state_e       state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] lck_q;

    logic             ld;
    logic [N-1:0]     lck_oh;
    logic [N-1:0]     qual;
    logic [N-1:0]     gnt;
    logic             xfer;
    logic             win_lst;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] ptr_nxt;
    logic [W-1:0]     mux_dat;

    req_vec_t         req_full;
    req_idx_t         ptr_full;
    req_vec_t         pick_full;
    req_vec_t         gnt_full;
    req_idx_t         idx_full;
    logic             unused_hi;

    // The output register may load when it is empty or being drained.
    assign ld = !out_vld || out_rdy;

    // One-hot mask of the locked source.
    always_comb begin
        lck_oh        = '0;
        lck_oh[lck_q] = 1'b1;
    end

    // While locked only the owning source may compete.
    assign qual = (state_q == LOCK) ? (in_vld & lck_oh) : in_vld;

    // Widen request and pointer into the package helper types.
    always_comb begin
        req_full            = '0;
        req_full[N-1:0]     = qual;
        ptr_full            = '0;
        ptr_full[IDX_W-1:0] = ptr_q;
    end

    assign pick_full = rr_pick(req_full, ptr_full, N);

    // Grant only when the output register can accept the beat.
    assign gnt    = ld ? pick_full[N-1:0] : '0;
    assign in_rdy = gnt;
    assign xfer   = |gnt;

    // Winner index and its last flag; gnt is one-hot or zero.
    always_comb begin
        gnt_full        = '0;
        gnt_full[N-1:0] = gnt;
    end

    assign idx_full = onehot_to_idx(gnt_full);
    assign gnt_idx  = idx_full[IDX_W-1:0];
    assign win_lst  = |(gnt & in_lst);

    // The helpers are sized for MAX_N; the bits above N are always zero.
    assign unused_hi = ^{pick_full, idx_full};

    // Pointer moves one past the source whose packet just ended.
    assign ptr_nxt = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);

    libv_mux #(
        .N (N),
        .W (W)
    ) u_mux (
        .sel (gnt),
        .dat (in_dat),
        .y   (mux_dat)
    );

    // Arbiter FSM, pointer, lock index and output register.
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset along with control so the
        // outputs read as zero after reset rather than stale data.
        if (!rst_n) begin
            state_q <= ARB;
            ptr_q   <= '0;
            lck_q   <= '0;
            out_vld <= 1'b0;
            out_dat <= '0;
            out_lst <= 1'b0;
            out_gnt <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the pre-edge values, independent of statement order.
            if (ld) begin
                if (xfer) begin
                    out_vld <= 1'b1;
                    out_dat <= mux_dat;
                    out_lst <= win_lst;
                    out_gnt <= gnt;
                end else begin
                    out_vld <= 1'b0;
                end
            end

            if (xfer) begin
                case (state_q)
                    ARB: begin
                        if (win_lst) begin
                            ptr_q <= ptr_nxt;
                        end else begin
                            lck_q   <= gnt_idx;
                            state_q <= LOCK;
                        end
                    end
                    LOCK: begin
                        if (win_lst) begin
                            ptr_q   <= ptr_nxt;
                            state_q <= ARB;
                        end
                    end
                    default: state_q <= ARB;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_libv_rr_arb_stage.sv
// Self-checking bench for libv_rr_arb_stage (N=4, W=32).
// A behavioural model tracks pointer, lock owner and the output register
// and predicts in_rdy and all outputs every cycle; directed tables and
// sequences add hand-computed expectations for the documented cases.
module tb_libv_rr_arb_stage;

    localparam int N = 4;
    localparam int W = 32;

    logic                clk;
    logic                rst_n;
    logic [N-1:0]        in_vld;
    logic [N-1:0][W-1:0] in_dat;
    logic [N-1:0]        in_lst;
    logic [N-1:0]        in_rdy;
    logic                out_vld;
    logic [W-1:0]        out_dat;
    logic                out_lst;
    logic [N-1:0]        out_gnt;
    logic                out_rdy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int           m_ptr;
    bit           m_lock;
    int           m_lck;
    bit           m_vld;
    logic [W-1:0] m_dat;
    bit           m_lst;
    logic [N-1:0] m_gnt;

    typedef struct {
        logic [N-1:0] vld;
        logic [N-1:0] lst;
        logic         ordy;
        logic [N-1:0] exp_rdy;
    } vec_t;

    vec_t tbl[10];

    libv_rr_arb_stage #(
        .N (N),
        .W (W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (in_vld),
        .in_dat  (in_dat),
        .in_lst  (in_lst),
        .in_rdy  (in_rdy),
        .out_vld (out_vld),
        .out_dat (out_dat),
        .out_lst (out_lst),
        .out_gnt (out_gnt),
        .out_rdy (out_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Requester that should be granted now: first valid at or after ptr
    // (mod N), restricted to the lock owner mid-packet; none if the output
    // register is full and not draining.
    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        int           i;
        g = '0;
        if (!m_vld || out_rdy) begin
            for (int k = 0; k < N; k++) begin
                i = (m_ptr + k) % N;
                if (g == '0 && in_vld[i] && (!m_lock || i == m_lck)) begin
                    g[i] = 1'b1;
                end
            end
        end
        return g;
    endfunction

    // Advance the model by one rising edge using the current inputs.
    task automatic model_clock();
        logic [N-1:0] g;
        int           w;
        if (!rst_n) begin
            m_ptr  = 0;
            m_lock = 0;
            m_lck  = 0;
            m_vld  = 0;
            m_dat  = '0;
            m_lst  = 0;
            m_gnt  = '0;
        end else begin
            g = model_grant();
            if (g != '0) begin
                w = 0;
                for (int i = 0; i < N; i++) begin
                    if (g[i]) w = i;
                end
                m_vld = 1;
                m_dat = in_dat[w];
                m_lst = in_lst[w];
                m_gnt = g;
                if (in_lst[w]) begin
                    m_ptr  = (w + 1) % N;
                    m_lock = 0;
                end else begin
                    m_lock = 1;
                    m_lck  = w;
                end
            end else if (!m_vld || out_rdy) begin
                m_vld = 0;
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "/in_rdy"},  64'(in_rdy),  64'(model_grant()));
        check({tag, "/out_vld"}, 64'(out_vld), 64'(m_vld));
        check({tag, "/out_gnt"}, 64'(out_gnt), 64'(m_gnt));
        check({tag, "/out_lst"}, 64'(out_lst), 64'(m_lst));
        check({tag, "/out_dat"}, 64'(out_dat), 64'(m_dat));
    endtask

    // Inputs are driven just after the falling edge; checks happen 1ns
    // later, then the model follows the DUT across the rising edge.
    task automatic step(input string tag);
        #1;
        check_model(tag);
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] vld, input logic [N-1:0] lst, input logic ordy);
        in_vld  = vld;
        in_lst  = lst;
        out_rdy = ordy;
        for (int i = 0; i < N; i++) begin
            in_dat[i] = $urandom;
        end
    endtask

    logic [W-1:0] held_dat;
    logic [N-1:0] held_gnt;

    initial begin
        // Round-robin over four requesters, then a lone requester 3.
        tbl[0] = '{vld: 4'b1111, lst: 4'b1111, ordy: 1'b1, exp_rdy: 4'b0001};
        tbl[1] = '{vld: 4'b1111, lst: 4'b1111, ordy: 1'b1, exp_rdy: 4'b0010};
        tbl[2] = '{vld: 4'b1111, lst: 4'b1111, ordy: 1'b1, exp_rdy: 4'b0100};
        tbl[3] = '{vld: 4'b1111, lst: 4'b1111, ordy: 1'b1, exp_rdy: 4'b1000};
        tbl[4] = '{vld: 4'b1111, lst: 4'b1111, ordy: 1'b1, exp_rdy: 4'b0001};
        tbl[5] = '{vld: 4'b1000, lst: 4'b1000, ordy: 1'b1, exp_rdy: 4'b1000};
        tbl[6] = '{vld: 4'b1000, lst: 4'b1000, ordy: 1'b1, exp_rdy: 4'b1000};
        tbl[7] = '{vld: 4'b1000, lst: 4'b1000, ordy: 1'b1, exp_rdy: 4'b1000};
        tbl[8] = '{vld: 4'b1000, lst: 4'b1000, ordy: 1'b0, exp_rdy: 4'b0000};
        tbl[9] = '{vld: 4'b1000, lst: 4'b1000, ordy: 1'b1, exp_rdy: 4'b1000};

        // Reset for two cycles; the first edge brings the DUT out of X.
        rst_n = 1'b0;
        drive('0, '0, 1'b0);
        @(posedge clk);
        model_clock();
        @(negedge clk);
        step("reset");
        #1;
        check("reset/out_vld", 64'(out_vld), 64'd0);
        check("reset/out_gnt", 64'(out_gnt), 64'd0);
        check("reset/in_rdy",  64'(in_rdy),  64'd0);
        rst_n = 1'b1;
        step("idle");

        // Table-driven vectors.
        for (int v = 0; v < 10; v++) begin
            drive(tbl[v].vld, tbl[v].lst, tbl[v].ordy);
            #1;
            check($sformatf("tbl%0d/in_rdy", v), 64'(in_rdy), 64'(tbl[v].exp_rdy));
            step($sformatf("tbl%0d", v));
        end

        // Packet lock: advance ptr to 1, then req1 sends 3 beats.
        drive(4'b0001, 4'b0001, 1'b1);
        step("lock/pre");
        for (int b = 0; b < 3; b++) begin
            drive(4'b0111, (b == 2) ? 4'b0111 : 4'b0101, 1'b1);
            #1;
            check($sformatf("lock/beat%0d", b), 64'(in_rdy), 64'b0010);
            step("lock");
        end
        drive(4'b0111, 4'b0111, 1'b1);
        #1;
        check("lock/after_rdy", 64'(in_rdy),  64'b0100);
        check("lock/last_gnt",  64'(out_gnt), 64'b0010);
        check("lock/last_lst",  64'(out_lst), 64'd1);
        step("lock/after");

        // Idle in LOCK: ptr=3, req1 starts a packet then goes quiet.
        drive(4'b0010, 4'b0000, 1'b1);
        step("idlelock/start");
        for (int c = 0; c < 2; c++) begin
            drive(4'b0101, 4'b0101, 1'b1);
            #1;
            check("idlelock/no_grant", 64'(in_rdy), 64'd0);
            step("idlelock");
        end
        drive(4'b0010, 4'b0010, 1'b1);
        #1;
        check("idlelock/resume", 64'(in_rdy), 64'b0010);
        step("idlelock/end");

        // Backpressure: load a beat, stall 5 cycles, then drain+load.
        drive(4'b0001, 4'b0001, 1'b1);
        step("bp/load");
        #1;
        held_dat = out_dat;
        held_gnt = out_gnt;
        for (int c = 0; c < 5; c++) begin
            drive(4'b1111, 4'b1111, 1'b0);
            #1;
            check("bp/in_rdy",  64'(in_rdy),  64'd0);
            check("bp/out_dat", 64'(out_dat), 64'(held_dat));
            check("bp/out_gnt", 64'(out_gnt), 64'(held_gnt));
            check("bp/out_vld", 64'(out_vld), 64'd1);
            step("bp/stall");
        end
        drive(4'b1111, 4'b1111, 1'b1);
        #1;
        check("bp/drain_rdy", 64'(|in_rdy), 64'd1);
        step("bp/drain");
        #1;
        check("bp/no_bubble", 64'(out_vld), 64'd1);

        // Reset mid-packet: lock on req2, then reset.
        drive(4'b0100, 4'b0000, 1'b1);
        step("rstmid/lock");
        rst_n = 1'b0;
        drive(4'b0101, 4'b0101, 1'b1);
        step("rstmid/rst");
        rst_n = 1'b1;
        drive(4'b0101, 4'b0101, 1'b1);
        #1;
        check("rstmid/out_vld", 64'(out_vld), 64'd0);
        check("rstmid/first",   64'(in_rdy),  64'b0001);
        step("rstmid/after");

        // Randomised traffic against the model, with rare resets.
        for (int c = 0; c < 400; c++) begin
            drive(4'($urandom), 4'($urandom), ($urandom_range(0, 9) < 7));
            rst_n = ($urandom_range(0, 99) != 0);
            step($sformatf("rand%0d", c));
        end
        rst_n = 1'b1;
        drive('0, '0, 1'b1);
        step("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
